// File: rtl/clint_ctrl_pkg.sv
// rtl/clint_ctrl_pkg.sv - shared encodings, CSR addresses, cause codes and FSM states for clint_ctrl
package clint_ctrl_pkg;

   localparam logic [31:0] YSYX_22050698_INST_ECALL  = 32'h0000_0073;
   localparam logic [31:0] YSYX_22050698_INST_EBREAK = 32'h0010_0073;
   localparam logic [31:0] YSYX_22050698_INST_MRET   = 32'h3020_0073;

   localparam logic [63:0] YSYX_22050698_CSR_MSTATUS = 64'h300;
   localparam logic [63:0] YSYX_22050698_CSR_MEPC    = 64'h341;
   localparam logic [63:0] YSYX_22050698_CSR_MCAUSE  = 64'h342;

   localparam logic [63:0] YSYX_22050698_CAUSE_ECALL  = 64'd11;
   localparam logic [63:0] YSYX_22050698_CAUSE_EBREAK = 64'd3;
   localparam logic [63:0] YSYX_22050698_CAUSE_TIMER  = 64'h8000_0000_0000_0007;

   localparam logic [2:0] YSYX_22050698_ST_IDLE         = 3'd0;
   localparam logic [2:0] YSYX_22050698_ST_MEPC         = 3'd1;
   localparam logic [2:0] YSYX_22050698_ST_MSTATUS      = 3'd2;
   localparam logic [2:0] YSYX_22050698_ST_MCAUSE       = 3'd3;
   localparam logic [2:0] YSYX_22050698_ST_ASSERT       = 3'd4;
   localparam logic [2:0] YSYX_22050698_ST_MRET_MSTATUS = 3'd5;

   // Trap entry: MPIE takes the old MIE, MIE is cleared.
   function automatic logic [63:0] trap_mstatus(input logic [63:0] s);
      logic [63:0] r;
      r    = s;
      r[7] = s[3];
      r[3] = 1'b0;
      return r;
   endfunction

   // Trap return: MIE restored from MPIE, MPIE set.
   function automatic logic [63:0] mret_mstatus(input logic [63:0] s);
      logic [63:0] r;
      r    = s;
      r[3] = s[7];
      r[7] = 1'b1;
      return r;
   endfunction

endpackage

// File: rtl/clint_ctrl_if.sv
// rtl/clint_ctrl_if.sv - CSR register-file port between clint_ctrl (master) and the CSR file (slave)
interface clint_ctrl_if;
   logic [63:0] csr_mtvec_i;
   logic [63:0] csr_mepc_i;
   logic [63:0] csr_mstatus_i;
   logic        global_int_en_i;
   logic        we_o;
   logic [63:0] waddr_o;
   logic [63:0] raddr_o;
   logic [63:0] data_o;

   modport master (
      input  csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i,
      output we_o, waddr_o, raddr_o, data_o
   );

   modport slave (
      output csr_mtvec_i, csr_mepc_i, csr_mstatus_i, global_int_en_i,
      input  we_o, waddr_o, raddr_o, data_o
   );
endinterface

// File: rtl/clint_ctrl.sv
// rtl/clint_ctrl.sv - core-local trap/interrupt sequencer: ecall/ebreak/timer entry and mret return
module clint_ctrl
   import clint_ctrl_pkg::*;
#(
   parameter logic [63:0] ECALL_CAUSE  = YSYX_22050698_CAUSE_ECALL,
   parameter logic [63:0] EBREAK_CAUSE = YSYX_22050698_CAUSE_EBREAK,
   parameter logic [63:0] TIMER_CAUSE  = YSYX_22050698_CAUSE_TIMER
) (
   input  logic         clk,
   input  logic         rst,
   input  logic [31:0]  inst_i,
   input  logic [63:0]  inst_addr_i,
   input  logic         jump_flag_i,
   input  logic [63:0]  jump_addr_i,
   input  logic         hold_flag_i,
   input  logic         timer_irq_i,
   clint_ctrl_if.master csr,
   output logic         hold_o,
   output logic         int_assert_o,
   output logic [63:0]  int_addr_o
);

   logic [2:0]  state;
   logic [2:0]  state_nxt;
   logic [63:0] cause_q;
   logic [63:0] ret_q;
   logic        mret_q;

   logic        detect_en;
   logic        is_ecall;
   logic        is_ebreak;
   logic        is_mret;
   logic        is_irq;
   logic        trap_det;
   logic        mret_det;
   logic [63:0] det_cause;
   logic [63:0] det_ret;

   // Gating with rst keeps hold_o low while reset is asserted, even with an ecall in ID.
   assign detect_en = rst && (state == YSYX_22050698_ST_IDLE) && !hold_flag_i;
   assign is_ecall  = (inst_i == YSYX_22050698_INST_ECALL);
   assign is_ebreak = (inst_i == YSYX_22050698_INST_EBREAK);
   assign is_mret   = (inst_i == YSYX_22050698_INST_MRET);
   assign is_irq    = timer_irq_i && csr.global_int_en_i;

   assign trap_det  = detect_en && (is_ecall || is_ebreak || (!is_mret && is_irq));
   assign mret_det  = detect_en && !is_ecall && !is_ebreak && is_mret;

   always_comb begin
      det_cause = TIMER_CAUSE;
      det_ret   = jump_flag_i ? jump_addr_i : inst_addr_i;
      if (is_ecall) begin
         det_cause = ECALL_CAUSE;
         det_ret   = inst_addr_i;
      end else if (is_ebreak) begin
         det_cause = EBREAK_CAUSE;
         det_ret   = inst_addr_i;
      end
   end

   always_comb begin
      state_nxt = YSYX_22050698_ST_IDLE;
      case (state)
         YSYX_22050698_ST_IDLE: begin
            if (trap_det)      state_nxt = YSYX_22050698_ST_MEPC;
            else if (mret_det) state_nxt = YSYX_22050698_ST_MRET_MSTATUS;
         end
         YSYX_22050698_ST_MEPC:         state_nxt = YSYX_22050698_ST_MSTATUS;
         YSYX_22050698_ST_MSTATUS:      state_nxt = YSYX_22050698_ST_MCAUSE;
         YSYX_22050698_ST_MCAUSE:       state_nxt = YSYX_22050698_ST_ASSERT;
         YSYX_22050698_ST_MRET_MSTATUS: state_nxt = YSYX_22050698_ST_ASSERT;
         default:                       state_nxt = YSYX_22050698_ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state   <= YSYX_22050698_ST_IDLE;
         cause_q <= 64'd0;
         ret_q   <= 64'd0;
         mret_q  <= 1'b0;
      end else begin
         state <= state_nxt;
         if (trap_det) begin
            cause_q <= det_cause;
            ret_q   <= det_ret;
         end
         if (trap_det || mret_det) begin
            mret_q <= mret_det;
         end
      end
   end

   always_comb begin
      csr.we_o     = 1'b0;
      csr.waddr_o  = 64'd0;
      csr.data_o   = 64'd0;
      int_assert_o = 1'b0;
      int_addr_o   = 64'd0;
      case (state)
         YSYX_22050698_ST_MEPC: begin
            csr.we_o    = 1'b1;
            csr.waddr_o = YSYX_22050698_CSR_MEPC;
            csr.data_o  = ret_q;
         end
         YSYX_22050698_ST_MSTATUS: begin
            csr.we_o    = 1'b1;
            csr.waddr_o = YSYX_22050698_CSR_MSTATUS;
            csr.data_o  = trap_mstatus(csr.csr_mstatus_i);
         end
         YSYX_22050698_ST_MCAUSE: begin
            csr.we_o    = 1'b1;
            csr.waddr_o = YSYX_22050698_CSR_MCAUSE;
            csr.data_o  = cause_q;
         end
         YSYX_22050698_ST_MRET_MSTATUS: begin
            csr.we_o    = 1'b1;
            csr.waddr_o = YSYX_22050698_CSR_MSTATUS;
            csr.data_o  = mret_mstatus(csr.csr_mstatus_i);
         end
         YSYX_22050698_ST_ASSERT: begin
            int_assert_o = 1'b1;
            int_addr_o   = mret_q ? csr.csr_mepc_i : csr.csr_mtvec_i;
         end
         default: ;
      endcase
   end

   assign hold_o      = trap_det || mret_det || (state != YSYX_22050698_ST_IDLE);
   assign csr.raddr_o = rst ? YSYX_22050698_CSR_MSTATUS : 64'd0;

endmodule

// File: tb/tb_clint_ctrl.sv
// tb/tb_clint_ctrl.sv - self-checking bench for clint_ctrl with directed cases and a queue-based reference model
module tb_clint_ctrl;

    localparam logic [31:0] ECALL  = 32'h0000_0073;
    localparam logic [31:0] EBREAK = 32'h0010_0073;
    localparam logic [31:0] MRET   = 32'h3020_0073;
    localparam logic [31:0] NOP    = 32'h0000_0013;
    localparam logic [63:0] TCAUSE = 64'h8000_0000_0000_0007;

    localparam int K_DET = 0, K_MEPC = 1, K_MST_T = 2, K_MCAUSE = 3, K_AS_T = 4, K_MST_R = 5, K_AS_R = 6;

    typedef struct packed {
        logic        hold;
        logic        we;
        logic [63:0] waddr;
        logic [63:0] data;
        logic [63:0] raddr;
        logic        ia;
        logic [63:0] iaddr;
    } obs_t;

    typedef struct {
        int          k;
        logic [63:0] v;
    } item_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] inst;
    logic [63:0] inst_addr;
    logic        jump_flag;
    logic [63:0] jump_addr;
    logic        hold_flag;
    logic        timer_irq;
    logic        hold;
    logic        int_assert;
    logic [63:0] int_addr;

    int checks = 0;
    int errors = 0;

    clint_ctrl_if bus();

    clint_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .inst_i       (inst),
        .inst_addr_i  (inst_addr),
        .jump_flag_i  (jump_flag),
        .jump_addr_i  (jump_addr),
        .hold_flag_i  (hold_flag),
        .timer_irq_i  (timer_irq),
        .csr          (bus),
        .hold_o       (hold),
        .int_assert_o (int_assert),
        .int_addr_o   (int_addr)
    );

    always #5 clk = ~clk;

    function automatic obs_t sample();
        obs_t o;
        o.hold  = hold;
        o.we    = bus.we_o;
        o.waddr = bus.waddr_o;
        o.data  = bus.data_o;
        o.raddr = bus.raddr_o;
        o.ia    = int_assert;
        o.iaddr = int_addr;
        return o;
    endfunction

    function automatic obs_t mk(logic h, logic w, logic [63:0] wa, logic [63:0] d, logic a, logic [63:0] ad);
        obs_t o;
        o.hold  = h;
        o.we    = w;
        o.waddr = wa;
        o.data  = d;
        o.raddr = 64'h300;
        o.ia    = a;
        o.iaddr = ad;
        return o;
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        inst                = NOP;
        inst_addr           = 64'h8000_0000;
        jump_flag           = 1'b0;
        jump_addr           = 64'd0;
        hold_flag           = 1'b0;
        timer_irq           = 1'b0;
        bus.csr_mtvec_i     = 64'h8000_0400;
        bus.csr_mepc_i      = 64'h0;
        bus.csr_mstatus_i   = 64'h8;
        bus.global_int_en_i = 1'b0;
    endtask

    task automatic test_reset();
        obs_t o;
        idle_inputs();
        rst  = 1'b0;
        inst = ECALL;
        #3;
        o = sample();
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_outputs got %h exp %h", o, obs_t'(0));
        end
        cyc();
        cyc();
        inst = NOP;
        rst  = 1'b1;
        #2;
        o = sample();
        checks++;
        if (o !== mk(0, 0, 0, 0, 0, 0)) begin
            errors++;
            $display("FAIL reset_release got %h exp %h", o, mk(0, 0, 0, 0, 0, 0));
        end
        cyc();
    endtask

    task automatic test_ecall();
        obs_t o;
        obs_t e[6];
        e = '{mk(1, 0, 0, 0, 0, 0), mk(1, 1, 64'h341, 64'h8000_0100, 0, 0),
              mk(1, 1, 64'h300, 64'h80, 0, 0), mk(1, 1, 64'h342, 64'd11, 0, 0),
              mk(1, 0, 0, 0, 1, 64'h8000_0400), mk(0, 0, 0, 0, 0, 0)};
        idle_inputs();
        inst_addr = 64'h8000_0100;
        inst      = ECALL;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) inst = NOP;
            #2;
            o = sample();
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL ecall c%0d got %h exp %h", i, o, e[i]);
            end
            cyc();
        end
    endtask

    task automatic test_timer_jump();
        obs_t o;
        obs_t e[6];
        e = '{mk(1, 0, 0, 0, 0, 0), mk(1, 1, 64'h341, 64'h8000_0200, 0, 0),
              mk(1, 1, 64'h300, 64'h80, 0, 0), mk(1, 1, 64'h342, TCAUSE, 0, 0),
              mk(1, 0, 0, 0, 1, 64'h8000_0400), mk(0, 0, 0, 0, 0, 0)};
        idle_inputs();
        inst_addr           = 64'h8000_0300;
        jump_flag           = 1'b1;
        jump_addr           = 64'h8000_0200;
        timer_irq           = 1'b1;
        bus.global_int_en_i = 1'b1;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                timer_irq = 1'b0;
                jump_flag = 1'b0;
            end
            #2;
            o = sample();
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL timer_jump c%0d got %h exp %h", i, o, e[i]);
            end
            cyc();
        end
    endtask

    task automatic test_mret();
        obs_t o;
        obs_t e[4];
        e = '{mk(1, 0, 0, 0, 0, 0), mk(1, 1, 64'h300, 64'h88, 0, 0),
              mk(1, 0, 0, 0, 1, 64'h8000_0104), mk(0, 0, 0, 0, 0, 0)};
        idle_inputs();
        bus.csr_mepc_i    = 64'h8000_0104;
        bus.csr_mstatus_i = 64'h80;
        inst              = MRET;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) inst = NOP;
            #2;
            o = sample();
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL mret c%0d got %h exp %h", i, o, e[i]);
            end
            cyc();
        end
    endtask

    task automatic test_mie_off();
        obs_t o;
        idle_inputs();
        timer_irq           = 1'b1;
        bus.global_int_en_i = 1'b0;
        for (int i = 0; i < 4; i++) begin
            #2;
            o = sample();
            checks++;
            if (o !== mk(0, 0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL mie_off c%0d got %h exp %h", i, o, mk(0, 0, 0, 0, 0, 0));
            end
            cyc();
        end
    endtask

    task automatic test_priority();
        obs_t o;
        obs_t e[6];
        e = '{mk(1, 0, 0, 0, 0, 0), mk(1, 1, 64'h341, 64'h8000_0100, 0, 0),
              mk(1, 1, 64'h300, 64'h80, 0, 0), mk(1, 1, 64'h342, 64'd11, 0, 0),
              mk(1, 0, 0, 0, 1, 64'h8000_0400), mk(0, 0, 0, 0, 0, 0)};
        idle_inputs();
        inst_addr           = 64'h8000_0100;
        jump_flag           = 1'b1;
        jump_addr           = 64'h8000_0900;
        bus.csr_mstatus_i   = 64'h88;
        timer_irq           = 1'b1;
        bus.global_int_en_i = 1'b1;
        inst                = ECALL;
        for (int i = 0; i < 6; i++) begin
            if (i == 1) begin
                inst      = NOP;
                timer_irq = 1'b0;
            end
            #2;
            o = sample();
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL priority c%0d got %h exp %h", i, o, e[i]);
            end
            cyc();
        end
    endtask

    task automatic test_hold();
        obs_t o;
        obs_t e[9];
        e = '{mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0),
              mk(1, 0, 0, 0, 0, 0), mk(1, 1, 64'h341, 64'h8000_0100, 0, 0),
              mk(1, 1, 64'h300, 64'h80, 0, 0), mk(1, 1, 64'h342, 64'd11, 0, 0),
              mk(1, 0, 0, 0, 1, 64'h8000_0400), mk(0, 0, 0, 0, 0, 0)};
        idle_inputs();
        inst_addr = 64'h8000_0100;
        inst      = ECALL;
        hold_flag = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i == 3) hold_flag = 1'b0;
            if (i == 4) hold_flag = 1'b1;
            #2;
            o = sample();
            checks++;
            if (o !== e[i]) begin
                errors++;
                $display("FAIL hold c%0d got %h exp %h", i, o, e[i]);
            end
            cyc();
        end
        idle_inputs();
        cyc();
    endtask

    task automatic test_reset_mid();
        obs_t o;
        idle_inputs();
        inst_addr = 64'h8000_0100;
        inst      = ECALL;
        cyc();
        inst = NOP;
        cyc();
        #1;
        o = sample();
        checks++;
        if (o !== mk(1, 1, 64'h300, 64'h80, 0, 0)) begin
            errors++;
            $display("FAIL reset_mid_pre got %h exp %h", o, mk(1, 1, 64'h300, 64'h80, 0, 0));
        end
        rst = 1'b0;
        #1;
        o = sample();
        checks++;
        if (o !== obs_t'(0)) begin
            errors++;
            $display("FAIL reset_mid_async got %h exp %h", o, obs_t'(0));
        end
        cyc();
        rst = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #2;
            o = sample();
            checks++;
            if (o !== mk(0, 0, 0, 0, 0, 0)) begin
                errors++;
                $display("FAIL reset_mid_after c%0d got %h exp %h", i, o, mk(0, 0, 0, 0, 0, 0));
            end
            cyc();
        end
    endtask

    task automatic test_random();
        obs_t        o;
        obs_t        e;
        item_t       q[$];
        item_t       it;
        logic [63:0] s;
        logic [63:0] ret;
        logic [63:0] cause;
        int          r;
        idle_inputs();
        for (int n = 0; n < 3000; n++) begin
            r = $urandom_range(0, 9);
            if (r < 2)      inst = ECALL;
            else if (r < 3) inst = EBREAK;
            else if (r < 4) inst = MRET;
            else if (r < 5) inst = $urandom;
            else            inst = NOP;
            inst_addr           = {$urandom, $urandom};
            jump_addr           = {$urandom, $urandom};
            jump_flag           = 1'($urandom_range(0, 1));
            hold_flag           = ($urandom_range(0, 3) == 0);
            timer_irq           = ($urandom_range(0, 3) == 0);
            bus.global_int_en_i = 1'($urandom_range(0, 1));
            bus.csr_mtvec_i     = {$urandom, $urandom};
            bus.csr_mepc_i      = {$urandom, $urandom};
            bus.csr_mstatus_i   = {$urandom, $urandom};

            if (q.size() == 0 && !hold_flag) begin
                ret   = 64'd0;
                cause = 64'd0;
                if (inst == ECALL || inst == EBREAK) begin
                    ret   = inst_addr;
                    cause = (inst == ECALL) ? 64'd11 : 64'd3;
                end else if (inst != MRET && timer_irq && bus.global_int_en_i) begin
                    ret   = jump_flag ? jump_addr : inst_addr;
                    cause = TCAUSE;
                end
                if (inst == MRET && cause == 64'd0) begin
                    q.push_back('{K_DET, 64'd0});
                    q.push_back('{K_MST_R, 64'd0});
                    q.push_back('{K_AS_R, 64'd0});
                end else if (cause != 64'd0) begin
                    q.push_back('{K_DET, 64'd0});
                    q.push_back('{K_MEPC, ret});
                    q.push_back('{K_MST_T, 64'd0});
                    q.push_back('{K_MCAUSE, cause});
                    q.push_back('{K_AS_T, 64'd0});
                end
            end

            s = bus.csr_mstatus_i;
            e = mk(0, 0, 0, 0, 0, 0);
            if (q.size() != 0) begin
                it = q.pop_front();
                case (it.k)
                    K_DET:    e = mk(1, 0, 0, 0, 0, 0);
                    K_MEPC:   e = mk(1, 1, 64'h341, it.v, 0, 0);
                    K_MST_T:  e = mk(1, 1, 64'h300, (s & ~64'h88) | (s[3] ? 64'h80 : 64'h0), 0, 0);
                    K_MCAUSE: e = mk(1, 1, 64'h342, it.v, 0, 0);
                    K_AS_T:   e = mk(1, 0, 0, 0, 1, bus.csr_mtvec_i);
                    K_MST_R:  e = mk(1, 1, 64'h300, (s & ~64'h8) | 64'h80 | (s[7] ? 64'h8 : 64'h0), 0, 0);
                    default:  e = mk(1, 0, 0, 0, 1, bus.csr_mepc_i);
                endcase
            end

            #2;
            o = sample();
            checks++;
            if (o !== e) begin
                errors++;
                if (errors <= 20) $display("FAIL random c%0d got %h exp %h", n, o, e);
            end
            cyc();
        end
    endtask

    initial begin
        test_reset();
        test_ecall();
        test_timer_jump();
        test_mret();
        test_mie_off();
        test_priority();
        test_hold();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
